// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: DEPTH-word data memory, optional multi-cycle access, MEM/WB register.
// Optional misaligned-access trap is enabled with the MEM_MISALIGN_TRAP_EN macro.
module mem_stage_lsu #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

  typedef enum logic { IDLE, WAIT } state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic        misalign;
  } wb_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  wb_t         w_q, w_d;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic          is_store, is_load, is_half, is_word, misalign, access;
  logic          stall, complete;
  logic [31:0]   rd_word, load_data, wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    be;

  assign word_idx = ALU_ResultM[AW+1:2];
  assign off      = ALU_ResultM[1:0];
  // A simultaneous read+write request is a store.
  assign is_store = MemWriteM;
  assign is_load  = MemReadM & ~MemWriteM;
  assign is_half  = (Funct3M == 3'b001) | (is_load & (Funct3M == 3'b101));
  assign is_word  = (Funct3M == 3'b010);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (is_store | is_load) &
                    ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign access = (is_store | is_load) & ~misalign;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    if (WAIT_CYCLES == 0) begin
      complete = access;
    end else begin
      case (state_q)
        IDLE: if (access) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = 3'd1;
        end
        WAIT: if (cnt_q == WAIT_N) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 3'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 3'd1;
        end
      endcase
    end
  end

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    case (Funct3M)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (Funct3M)
      3'b000: begin
        be    = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      3'b010: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_d = '0;
    if (!stall) begin
      w_d.reg_write  = RegWriteM & ~misalign;
      w_d.result_src = ResultSrcM;
      w_d.rd         = RD_M;
      w_d.pc_plus4   = PCPlus4M;
      w_d.alu_result = ALU_ResultM;
      w_d.read_data  = (is_load & ~misalign) ? load_data : 32'd0;
      w_d.misalign   = misalign;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  // NOTE: the data array is deliberately not reset; reset only blocks the write of an aborted store.
  always_ff @(posedge clk) begin
    if (!rst && complete && is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign StallM      = stall;
  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RD_W        = w_q.rd;
  assign PCPlus4W    = w_q.pc_plus4;
  assign ALU_ResultW = w_q.alu_result;
  assign ReadDataW   = w_q.read_data;
  assign MisalignW   = w_q.misalign;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: one instance with WAIT_CYCLES=0 and one with WAIT_CYCLES=3,
// checked against a byte-level memory model.
module tb_mem_stage_lsu;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic        rw, mw, mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
  } m_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc4, alu, rdata;
    logic        mis;
  } w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  m_t   m0 = '0, m3 = '0;
  logic        stall0, stall3, rw0, rw3, mis0, mis3;
  logic [1:0]  rs0, rs3;
  logic [4:0]  rd0, rd3;
  logic [31:0] pc0, pc3, alu0, alu3, rdat0, rdat3;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [2][DEPTH];

  always #5 clk = ~clk;

  mem_stage_lsu #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .RegWriteM(m0.rw), .MemWriteM(m0.mw), .MemReadM(m0.mr),
    .ResultSrcM(m0.rs), .Funct3M(m0.f3), .RD_M(m0.rd), .PCPlus4M(m0.pc4),
    .WriteDataM(m0.wd), .ALU_ResultM(m0.alu), .StallM(stall0), .RegWriteW(rw0),
    .ResultSrcW(rs0), .RD_W(rd0), .PCPlus4W(pc0), .ALU_ResultW(alu0),
    .ReadDataW(rdat0), .MisalignW(mis0));

  mem_stage_lsu #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .RegWriteM(m3.rw), .MemWriteM(m3.mw), .MemReadM(m3.mr),
    .ResultSrcM(m3.rs), .Funct3M(m3.f3), .RD_M(m3.rd), .PCPlus4M(m3.pc4),
    .WriteDataM(m3.wd), .ALU_ResultM(m3.alu), .StallM(stall3), .RegWriteW(rw3),
    .ResultSrcW(rs3), .RD_W(rd3), .PCPlus4W(pc3), .ALU_ResultW(alu3),
    .ReadDataW(rdat3), .MisalignW(mis3));

  function automatic w_t get_w(input bit which);
    w_t w;
    if (which) begin
      w.rw = rw3; w.rs = rs3; w.rd = rd3; w.pc4 = pc3; w.alu = alu3; w.rdata = rdat3; w.mis = mis3;
    end else begin
      w.rw = rw0; w.rs = rs0; w.rd = rd0; w.pc4 = pc0; w.alu = alu0; w.rdata = rdat0; w.mis = mis0;
    end
    return w;
  endfunction

  function automatic m_t st_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    m_t m = '0;
    m.mw = 1'b1; m.f3 = f3; m.alu = a; m.wd = d; m.pc4 = 32'h0000_0400; m.rd = 5'd3;
    return m;
  endfunction

  function automatic m_t ld_op(input logic [2:0] f3, input logic [31:0] a);
    m_t m = '0;
    m.mr = 1'b1; m.rw = 1'b1; m.rs = 2'b01; m.f3 = f3; m.alu = a; m.rd = 5'd9; m.pc4 = 32'h0000_0100;
    return m;
  endfunction

  // Reference: an access touches `size` bytes starting at the size-aligned offset of its word.
  task automatic model(input bit which, input m_t m, output w_t e, output int est);
    int idx, off, size, base;
    bit st, ld, sgn, mis;
    logic [31:0] val;
    idx = int'(m.alu[AW+1:2]);
    off = int'(m.alu[1:0]);
    st = m.mw; ld = m.mr && !m.mw;
    size = 0; sgn = 0; mis = 0; val = '0;
    if (st) begin
      case (m.f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else if (ld) begin
      case (m.f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
`ifdef MEM_MISALIGN_TRAP_EN
    if (size > 1) mis = (off % size) != 0;
`endif
    if (!mis && size > 0) begin
      base = off - (off % size);
      for (int i = 0; i < size; i++) begin
        if (st) ref_mem[which][idx][8*(base+i) +: 8] = m.wd[8*i +: 8];
        else    val[8*i +: 8] = ref_mem[which][idx][8*(base+i) +: 8];
      end
      if (ld && sgn) for (int b = 8*size; b < 32; b++) val[b] = val[8*size-1];
    end
    e.rw = m.rw && !mis; e.rs = m.rs; e.rd = m.rd; e.pc4 = m.pc4; e.alu = m.alu;
    e.rdata = (ld && !mis) ? val : 32'd0;
    e.mis = mis;
    est = ((st || ld) && !mis) ? (which ? 3 : 0) : 0;
  endtask

  task automatic drive(input bit which, input m_t m);
    if (which) m3 = m; else m0 = m;
  endtask

  // Entered and left at a falling edge; every stall cycle must be followed by a bubble in W.
  task automatic exec(input bit which, input m_t m, output w_t w, output int stalls,
                      output w_t e, output int est);
    bit done;
    done = 0; stalls = 0; w = '0;
    model(which, m, e, est);
    drive(which, m);
    for (int k = 0; k < 16 && !done; k++) begin
      #1;
      if ((which ? stall3 : stall0) === 1'b1) begin
        stalls++;
        @(posedge clk); #1;
        checks++;
        if (get_w(which) !== '0) begin
          errors++;
          $display("FAIL bubble dut%0d: W=%h required 0", which ? 3 : 0, get_w(which));
        end
        @(negedge clk);
      end else begin
        @(posedge clk); #1;
        w = get_w(which);
        done = 1;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL stall_timeout dut%0d: still stalled after 16 cycles", which ? 3 : 0);
    end
    drive(which, '0);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (get_w(0) !== '0) begin errors++; $display("FAIL reset_w0: got %h required 0", get_w(0)); end
    checks++;
    if (get_w(1) !== '0) begin errors++; $display("FAIL reset_w3: got %h required 0", get_w(1)); end
    checks++;
    if (stall0 !== 1'b0 || stall3 !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b%b required 00", stall0, stall3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_no_wait();
    w_t w, e; int s, es;
    exec(0, st_op(3'b010, 32'h10, 32'hDEADBEEF), w, s, e, es);
    cmp("sw_stall", 32'(s), 32'd0);
    exec(0, ld_op(3'b010, 32'h10), w, s, e, es);
    cmp("lw_data", w.rdata, 32'hDEADBEEF);
    cmp("lw_regwrite", {31'd0, w.rw}, 32'd1);
    cmp("lw_stall", 32'(s), 32'd0);
    exec(0, st_op(3'b010, 32'h10, 32'h0), w, s, e, es);
    exec(0, st_op(3'b000, 32'h13, 32'h80), w, s, e, es);
    exec(0, ld_op(3'b000, 32'h13), w, s, e, es);
    cmp("lb_sext", w.rdata, 32'hFFFFFF80);
    exec(0, ld_op(3'b100, 32'h13), w, s, e, es);
    cmp("lbu_zext", w.rdata, 32'h00000080);
    exec(0, ld_op(3'b010, 32'h10), w, s, e, es);
    cmp("lw_after_sb", w.rdata, 32'h80000000);
    cmp("lw_fields", w[$bits(w_t)-1:33], e[$bits(w_t)-1:33]);
  endtask

  task automatic test_wait_states();
    w_t w, e; int s, es;
    exec(1, st_op(3'b010, 32'h30, 32'h1234ABCD), w, s, e, es);
    cmp("wait_sw_stalls", 32'(s), 32'd3);
    exec(1, ld_op(3'b010, 32'h30), w, s, e, es);
    cmp("wait_lw_stalls", 32'(s), 32'd3);
    cmp("wait_lw_regwrite", {31'd0, w.rw}, 32'd1);
    cmp("wait_lw_data", w.rdata, 32'h1234ABCD);
  endtask

  task automatic test_misalign();
    w_t w, e; int s, es;
    exec(1, st_op(3'b010, 32'h10, 32'h12345678), w, s, e, es);
    exec(1, ld_op(3'b010, 32'h12), w, s, e, es);
`ifdef MEM_MISALIGN_TRAP_EN
    cmp("mis_lw_flag", {31'd0, w.mis}, 32'd1);
    cmp("mis_lw_regwrite", {31'd0, w.rw}, 32'd0);
    cmp("mis_lw_stall", 32'(s), 32'd0);
    exec(1, st_op(3'b010, 32'h11, 32'hFFFFFFFF), w, s, e, es);
    exec(1, ld_op(3'b010, 32'h10), w, s, e, es);
    cmp("mis_sw_suppressed", w.rdata, 32'h12345678);
`else
    cmp("align_lw_data", w.rdata, 32'h12345678);
    cmp("align_lw_flag", {31'd0, w.mis}, 32'd0);
    exec(1, st_op(3'b010, 32'h11, 32'hFFFFFFFF), w, s, e, es);
    exec(1, ld_op(3'b010, 32'h10), w, s, e, es);
    cmp("align_sw_data", w.rdata, 32'hFFFFFFFF);
`endif
  endtask

  task automatic test_reset_in_wait();
    w_t w, e; int s, es;
    exec(1, st_op(3'b010, 32'h20, 32'h0BADF00D), w, s, e, es);
    m3 = st_op(3'b010, 32'h20, 32'h55);
    #1;
    cmp("abort_stall1", {31'd0, stall3}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp("abort_stall2", {31'd0, stall3}, 32'd1);
    rst = 1'b1;
    m3 = '0;
    @(posedge clk); #1;
    checks++;
    if (get_w(1) !== '0) begin errors++; $display("FAIL abort_w: got %h required 0", get_w(1)); end
    cmp("abort_stall_after", {31'd0, stall3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exec(1, ld_op(3'b010, 32'h20), w, s, e, es);
    cmp("abort_no_write", w.rdata, 32'h0BADF00D);
  endtask

  task automatic test_wrap();
    w_t w, e; int s, es;
    exec(0, st_op(3'b010, 32'(4*DEPTH+8), 32'hCAFEF00D), w, s, e, es);
    exec(0, ld_op(3'b010, 32'h8), w, s, e, es);
    cmp("wrap_data", w.rdata, 32'hCAFEF00D);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 3)) * 32'(4*DEPTH) + 32'(4*$urandom_range(0, 15))
           + 32'($urandom_range(0, 3));
  endfunction

  task automatic test_back_to_back();
    w_t w, e; int s, es;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = rand_addr();
      exec(i[0], st_op(3'($urandom_range(0, 2)), a, $urandom), w, s, e, es);
      exec(i[0], ld_op(3'b010, a), w, s, e, es);
      checks++;
      if (w !== e || s != es) begin
        errors++;
        $display("FAIL b2b_%0d: W=%h stalls=%0d required W=%h stalls=%0d", i, w, s, e, es);
      end
    end
  endtask

  task automatic test_random();
    w_t w, e; int s, es, kind;
    logic [2:0] ldc [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    logic [2:0] stc [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd7};
    m_t m;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) exec(d[0], st_op(3'b010, 32'(4*i), $urandom), w, s, e, es);
    for (int i = 0; i < 120; i++) begin
      m.rw = 1'($urandom); m.rs = 2'($urandom); m.rd = 5'($urandom);
      m.pc4 = $urandom; m.wd = $urandom;
      kind = $urandom_range(0, 3);
      m.mr = (kind == 1 || kind == 3);
      m.mw = (kind == 2 || kind == 3);
      m.f3 = m.mw ? stc[$urandom_range(0, 6)] : ldc[$urandom_range(0, 6)];
      m.alu = (kind == 0) ? $urandom : rand_addr();
      exec(i[0], m, w, s, e, es);
      checks++;
      if (w !== e || s != es) begin
        errors++;
        $display("FAIL random_%0d dut%0d: W=%h stalls=%0d required W=%h stalls=%0d",
                 i, i[0] ? 3 : 0, w, s, e, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_wait();
    test_wait_states();
    test_misalign();
    test_reset_in_wait();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
